// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
//   Register-bus connection between uart_tx_sched and a ZX-Uno-style UART.
//   master : the scheduler; drives u_addr, u_regrd, u_regwr, u_din and reads u_dout.
//   slave  : the UART; reads the bus strobes and drives u_dout (bit 6 = txbusy).
interface uart_tx_sched_if;
  logic [7:0] u_addr;
  logic       u_regrd;
  logic       u_regwr;
  logic [7:0] u_din;
  logic [7:0] u_dout;

  modport master (
    output u_addr,
    output u_regrd,
    output u_regwr,
    output u_din,
    input  u_dout
  );

  modport slave (
    input  u_addr,
    input  u_regrd,
    input  u_regwr,
    input  u_din,
    output u_dout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Transmit scheduler in front of a ZX-Uno-style UART (UARTDATA / UARTSTAT).
//   Two requesters push bytes into private FIFOs; bytes are granted round-robin,
//   the UART status is polled until txbusy is clear, the byte is written, and the
//   write is confirmed by seeing txbusy rise (or abandoned after ACK_TIMEOUT).
//   Ports:
//     clk_bus, rst_n        clock, async active-low reset
//     clk_div2, clk_div4    phase qualifiers; FSM advances when both are high
//     a_wr/a_data/a_full    requester A push strobe, byte, FIFO full
//     b_wr/b_data/b_full    requester B push strobe, byte, FIFO full
//     u                     UART register bus (master side)
//     busy                  FSM not idle or any FIFO non-empty
//     tx_err                sticky ACK-timeout flag

// Per-requester byte FIFO. Pushes while full are dropped; head is combinational.
module uart_tx_sched_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic       clk_bus,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rp];

  // Storage needs no reset: pointers define what is valid.
  always_ff @(posedge clk_bus) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module uart_tx_sched #(
  parameter int unsigned FIFO_AW     = 3,
  parameter logic [7:0]  UARTDATA    = 8'hC6,
  parameter logic [7:0]  UARTSTAT    = 8'hC7,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                  clk_bus,
  input  logic                  rst_n,
  input  logic                  clk_div2,
  input  logic                  clk_div4,
  input  logic                  a_wr,
  input  logic [7:0]            a_data,
  output logic                  a_full,
  input  logic                  b_wr,
  input  logic [7:0]            b_data,
  output logic                  b_full,
  uart_tx_sched_if.master       u,
  output logic                  busy,
  output logic                  tx_err
);
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_C = TW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_POLL, S_WRITE, S_ACK} state_t;

  state_t        state_q, state_d;
  logic          last_b_q, last_b_d;   // 1 = B holds the current/last grant
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_d;
  logic          ce;
  logic          txbusy;
  logic          a_empty, b_empty;
  logic [7:0]    a_head, b_head;
  logic          pop_a, pop_b;
  logic          unused_dout;

  assign ce          = clk_div2 & clk_div4;
  assign txbusy      = u.u_dout[6];
  assign unused_dout = ^{u.u_dout[7], u.u_dout[5:0]};

  uart_tx_sched_fifo #(.AW(FIFO_AW)) fifo_a (
    .clk_bus (clk_bus),
    .rst_n   (rst_n),
    .push    (a_wr),
    .din     (a_data),
    .pop     (pop_a),
    .head    (a_head),
    .empty   (a_empty),
    .full    (a_full)
  );

  uart_tx_sched_fifo #(.AW(FIFO_AW)) fifo_b (
    .clk_bus (clk_bus),
    .rst_n   (rst_n),
    .push    (b_wr),
    .din     (b_data),
    .pop     (pop_b),
    .head    (b_head),
    .empty   (b_empty),
    .full    (b_full)
  );

  assign busy = (state_q != S_IDLE) | ~a_empty | ~b_empty;

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      last_b_q <= 1'b1;
      tmo_q    <= '0;
      tx_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      tmo_q    <= tmo_d;
      tx_err   <= err_d;
    end
  end

  // Bus strobes depend only on the state register (and FIFO head), so they are
  // steady for the full ce period and collapse to 0 on async reset.
  always_comb begin
    state_d   = state_q;
    last_b_d  = last_b_q;
    tmo_d     = tmo_q;
    err_d     = tx_err;
    pop_a     = 1'b0;
    pop_b     = 1'b0;
    u.u_addr  = '0;
    u.u_regrd = 1'b0;
    u.u_regwr = 1'b0;
    u.u_din   = '0;
    case (state_q)
      S_IDLE: begin
        if (ce) begin
          if (!a_empty && !b_empty) begin
            last_b_d = ~last_b_q;
            state_d  = S_POLL;
          end else if (!a_empty) begin
            last_b_d = 1'b0;
            state_d  = S_POLL;
          end else if (!b_empty) begin
            last_b_d = 1'b1;
            state_d  = S_POLL;
          end
        end
      end
      S_POLL: begin
        u.u_addr  = UARTSTAT;
        u.u_regrd = 1'b1;
        if (ce && !txbusy) state_d = S_WRITE;
      end
      S_WRITE: begin
        u.u_addr  = UARTDATA;
        u.u_regwr = 1'b1;
        u.u_din   = last_b_q ? b_head : a_head;
        if (ce) begin
          pop_a   = ~last_b_q;
          pop_b   = last_b_q;
          tmo_d   = '0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        u.u_addr  = UARTSTAT;
        u.u_regrd = 1'b1;
        if (ce) begin
          if (txbusy) begin
            state_d = S_IDLE;
          end else begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q + 1'b1 == TMO_C) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
